// File: rtl/invsqrt_result_fifo.sv
// invsqrt_result_fifo: buffers single-precision results from the InvertSQRoot
// datapath for a downstream consumer. First-word-fall-through FIFO with
// occupancy flags, a sticky overflow flag and an accepted-sample counter.
// Optional feature macro: INVSQRT_SPECIAL_CHECK_EN -- when defined, NaN/Inf
// words (exponent all ones) are discarded and counted in SpecialCnt instead
// of being stored.
module invsqrt_result_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   DataIn,
    input  logic          DataInValid,
    output logic [31:0]   DataOut,
    output logic          DataOutValid,
    input  logic          DataOutReady,
    output logic          Full,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic          Overflow,
    output logic [15:0]   SampleCnt,
    output logic [7:0]    SpecialCnt
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic [15:0]   r_sample_cnt;

    logic          w_special;
    logic          w_offer;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_next;

`ifdef INVSQRT_SPECIAL_CHECK_EN
    logic [7:0]    r_special_cnt;

    // NaN and Inf share the all-ones exponent; neither is a usable result.
    function automatic logic f_is_special(input logic [31:0] word);
        return (word[30:23] == 8'hFF);
    endfunction
`endif

    // Decide push/pop/drop for this edge and the resulting occupancy.
    always_comb begin
        w_special = 1'b0;
`ifdef INVSQRT_SPECIAL_CHECK_EN
        w_special = DataInValid & f_is_special(DataIn);
`endif
        w_offer = DataInValid & ~w_special;
        // A pop needs a valid head, so a ready pulse while empty does nothing.
        w_pop   = ~r_empty & DataOutReady;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        w_push  = w_offer & (~r_full | w_pop);
        w_drop  = w_offer & r_full & ~w_pop;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
    end

    // Storage write; contents need no reset because Count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= DataIn;
        end
    end

    // Pointers, occupancy flags, sticky overflow and accepted-sample count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_overflow   <= 1'b0;
            r_sample_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
                r_sample_cnt <= r_sample_cnt + 16'h0001;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == {CW{1'b0}});
        end
    end

`ifdef INVSQRT_SPECIAL_CHECK_EN
    // Saturating count of discarded NaN/Inf results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_special_cnt <= 8'h00;
        end else if (w_special && (r_special_cnt != 8'hFF)) begin
            r_special_cnt <= r_special_cnt + 8'h01;
        end
    end

    assign SpecialCnt = r_special_cnt;
`else
    assign SpecialCnt = 8'h00;
`endif

    assign DataOutValid = ~r_empty;
    assign DataOut      = r_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
    assign Full         = r_full;
    assign Empty        = r_empty;
    assign Count        = r_count;
    assign Overflow     = r_overflow;
    assign SampleCnt    = r_sample_cnt;

endmodule

// File: tb/tb_invsqrt_result_fifo.sv
// Directed bench for invsqrt_result_fifo (DEPTH=16). Hand-written expected
// values plus a small queue model that tracks contents and counters.
module tb_invsqrt_result_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] DataIn = 32'h0;
    logic        DataInValid = 1'b0;
    logic [31:0] DataOut;
    logic        DataOutValid;
    logic        DataOutReady = 1'b0;
    logic        Full;
    logic        Empty;
    logic [4:0]  Count;
    logic        Overflow;
    logic [15:0] SampleCnt;
    logic [7:0]  SpecialCnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mq[$];
    logic        m_ovf  = 1'b0;
    logic [15:0] m_samp = 16'h0;
    logic [7:0]  m_spec = 8'h0;

    invsqrt_result_fifo #(.DEPTH(16), .CW(5)) dut (
        .clk(clk), .rst(rst), .DataIn(DataIn), .DataInValid(DataInValid),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
        .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
        .SampleCnt(SampleCnt), .SpecialCnt(SpecialCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_model(input string tag);
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        chk({tag, ".dout"},  DataOut, head);
        chk({tag, ".dov"},   {31'h0, DataOutValid}, {31'h0, mq.size() != 0});
        chk({tag, ".count"}, {27'h0, Count}, mq.size());
        chk({tag, ".empty"}, {31'h0, Empty}, {31'h0, mq.size() == 0});
        chk({tag, ".full"},  {31'h0, Full},  {31'h0, mq.size() == 16});
        chk({tag, ".ovf"},   {31'h0, Overflow}, {31'h0, m_ovf});
        chk({tag, ".samp"},  {16'h0, SampleCnt}, {16'h0, m_samp});
        chk({tag, ".spec"},  {24'h0, SpecialCnt}, {24'h0, m_spec});
    endtask

    // One clock edge with the given inputs; model follows.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy);
        bit pop;
        bit spec;
        pop  = rdy && (mq.size() != 0);
        spec = 1'b0;
`ifdef INVSQRT_SPECIAL_CHECK_EN
        spec = v && (d[30:23] == 8'hFF);
`endif
        DataInValid  = v;
        DataIn       = d;
        DataOutReady = rdy;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (spec) begin
            if (m_spec != 8'hFF) m_spec = m_spec + 8'h01;
        end else if (v) begin
            if (mq.size() < 16) begin
                mq.push_back(d);
                m_samp = m_samp + 16'h1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        DataInValid  = 1'b0;
        DataOutReady = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic [31:0] d);
        rst = 1'b1; DataInValid = v; DataIn = d; DataOutReady = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; DataInValid = 1'b0; DataOutReady = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_samp = 16'h0; m_spec = 8'h0;
    endtask

    logic [31:0] vec3 [3];

    initial begin
        vec3[0] = 32'h3F800000; vec3[1] = 32'h3F3504F3; vec3[2] = 32'h3F000000;

        // Reset state
        do_reset(1'b0, 32'h0);
        chk("rst.count", {27'h0, Count}, 32'd0);
        chk("rst.empty", {31'h0, Empty}, 32'd1);
        chk("rst.full",  {31'h0, Full},  32'd0);
        chk("rst.dov",   {31'h0, DataOutValid}, 32'd0);
        chk("rst.dout",  DataOut, 32'h0);
        chk("rst.ovf",   {31'h0, Overflow}, 32'd0);
        chk("rst.samp",  {16'h0, SampleCnt}, 32'd0);
        chk("rst.spec",  {24'h0, SpecialCnt}, 32'd0);

        // Ready pulse while empty does nothing
        step(1'b0, 32'h0, 1'b1);
        chk_model("rdy_empty");

        // Three results, then drain in order
        step(1'b1, vec3[0], 1'b0);
        chk("lat1.dout", DataOut, 32'h3F800000);
        chk("lat1.dov",  {31'h0, DataOutValid}, 32'd1);
        step(1'b1, vec3[1], 1'b0);
        step(1'b1, vec3[2], 1'b0);
        chk("three.count", {27'h0, Count}, 32'd3);
        chk("three.head",  DataOut, 32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain3.%0d", i), DataOut, vec3[i]);
            step(1'b0, 32'h0, 1'b1);
        end
        chk("drain3.empty", {31'h0, Empty}, 32'd1);
        chk("drain3.dout",  DataOut, 32'h0);

        // Fill to full, then overflow
        do_reset(1'b0, 32'h0);
        for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b0);
        chk("fill.full",  {31'h0, Full}, 32'd1);
        chk("fill.ovf",   {31'h0, Overflow}, 32'd0);
        chk("fill.count", {27'h0, Count}, 32'd16);
        step(1'b1, 32'h00000011, 1'b0);
        chk("ovf.set",   {31'h0, Overflow}, 32'd1);
        chk("ovf.count", {27'h0, Count}, 32'd16);
        chk("ovf.samp",  {16'h0, SampleCnt}, 32'd16);
        chk_model("ovf");
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("rd16.%0d", i), DataOut, i);
            step(1'b0, 32'h0, 1'b1);
        end
        chk("rd16.empty",  {31'h0, Empty}, 32'd1);
        chk("ovf.sticky",  {31'h0, Overflow}, 32'd1);

        // Full with simultaneous push and pop for 40 cycles
        do_reset(1'b0, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + i, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 32'h200 + k, 1'b1);
            chk_model($sformatf("pp.%0d", k));
        end
        chk("pp.count", {27'h0, Count}, 32'd16);
        chk("pp.ovf",   {31'h0, Overflow}, 32'd0);
        chk("pp.head",  DataOut, 32'h200 + 24);
        for (int i = 0; i < 16; i++) begin
            chk_model($sformatf("ppd.%0d", i));
            step(1'b0, 32'h0, 1'b1);
        end
        chk_model("ppd.end");

        // Reset mid-operation with a word offered
        do_reset(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + i, 1'b0);
        do_reset(1'b1, 32'h55555555);
        chk("mrst.count", {27'h0, Count}, 32'd0);
        chk("mrst.empty", {31'h0, Empty}, 32'd1);
        chk("mrst.dout",  DataOut, 32'h0);
        chk("mrst.samp",  {16'h0, SampleCnt}, 32'd0);
        step(1'b1, 32'hDEADBEEF, 1'b0);
        chk("mrst.first", DataOut, 32'hDEADBEEF);
        chk_model("mrst");

        // Special values
        do_reset(1'b0, 32'h0);
        step(1'b1, 32'h7FC00000, 1'b0);
        step(1'b1, 32'h7F800000, 1'b0);
        step(1'b1, 32'h3F800000, 1'b0);
`ifdef INVSQRT_SPECIAL_CHECK_EN
        chk("spc.count", {27'h0, Count}, 32'd1);
        chk("spc.spec",  {24'h0, SpecialCnt}, 32'd2);
        chk("spc.samp",  {16'h0, SampleCnt}, 32'd1);
        chk("spc.head",  DataOut, 32'h3F800000);
`else
        chk("spc.count", {27'h0, Count}, 32'd3);
        chk("spc.spec",  {24'h0, SpecialCnt}, 32'd0);
        chk("spc.samp",  {16'h0, SampleCnt}, 32'd3);
        chk("spc.head",  DataOut, 32'h7FC00000);
`endif
        chk_model("spc");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/invsqrt_result_fifo.md
INVSQRT_RESULT_FIFO -- requirements
Module: invsqrt_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of stored 32-bit words; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have parameter CW, default 5, meaning the Count width; it SHALL equal log2(DEPTH)+1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, and all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port DataIn, input, 32 bits: IEEE-754 single-precision result from the InvertSQRoot DataOut.
REQ-006 The block SHALL have port DataInValid, input, 1 bit: qualifies DataIn and is driven by InvertSQRoot DataValid; there is no backpressure upstream.
REQ-007 The block SHALL have port DataOut, output, 32 bits: the head word, shown ahead of the pop.
REQ-008 The block SHALL have port DataOutValid, output, 1 bit: high when the head word is valid.
REQ-009 The block SHALL have port DataOutReady, input, 1 bit: consumer accept.
REQ-010 The block SHALL have ports Full and Empty, outputs, 1 bit each: occupancy flags.
REQ-011 The block SHALL have port Count, output, CW bits: the number of stored words.
REQ-012 The block SHALL have port Overflow, output, 1 bit: sticky flag set when an offered word is dropped.
REQ-013 The block SHALL have port SampleCnt, output, 16 bits: the number of accepted words, wrapping modulo 2^16.
REQ-014 The block SHALL have port SpecialCnt, output, 8 bits: the number of discarded NaN/Inf words, saturating (see Configuration).

Function
REQ-015 A push SHALL occur on a clk edge with DataInValid=1 when either Full=0, or a pop occurs on the same edge.
REQ-016 A pop SHALL occur on a clk edge with DataOutValid=1 and DataOutReady=1.
REQ-017 DataOutValid SHALL equal not Empty, and DataOut SHALL equal the oldest stored word when not Empty and 32'h0 when Empty.
REQ-018 The write-to-read latency SHALL be 1 cycle: a word pushed at edge N into an empty FIFO SHALL appear on DataOut/DataOutValid after edge N.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-020 The order of words SHALL be strictly FIFO.
REQ-021 On each edge Count SHALL be +1 for a push only, -1 for a pop only, and unchanged for push+pop or for neither.
REQ-022 Empty SHALL be (Count==0) and Full SHALL be (Count==DEPTH); both SHALL be registered or derived so that they are valid in the same cycle as Count.
REQ-023 With Full=1, DataInValid=1 and no pop, the word SHALL be dropped, Overflow SHALL be set to 1, and storage and Count SHALL be unchanged.
REQ-024 Overflow SHALL clear only on rst.
REQ-025 With Full=1, DataInValid=1 and a simultaneous pop, the word SHALL be accepted, Count SHALL stay at DEPTH, and Overflow SHALL not be set.
REQ-026 With Empty=1 and DataInValid=1, the word SHALL be stored, and no pop SHALL occur in that cycle.
REQ-027 SampleCnt SHALL increment by 1 on each push and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 A DataOutReady pulse while Empty SHALL have no effect.

Reset
REQ-029 When rst=1 at an edge, pointers SHALL go to 0, Count to 0, Empty to 1, Full to 0, DataOutValid to 0, DataOut to 32'h0, Overflow to 0, SampleCnt to 0 and SpecialCnt to 0.
REQ-030 rst SHALL take priority over push and pop on the same edge, and the offered word SHALL be lost.
REQ-031 Reset asserted mid-operation SHALL discard all stored contents, and the first push after rst deasserts SHALL appear as the first word out.

Configuration
REQ-032 With INVSQRT_SPECIAL_CHECK_EN defined, a valid DataIn with exponent bits [30:23]==8'hFF SHALL not be pushed, SpecialCnt SHALL increment and saturate at 255, and SampleCnt and Overflow SHALL be unaffected even when the FIFO is full.
REQ-033 Without INVSQRT_SPECIAL_CHECK_EN, all valid words SHALL be treated as data, and SpecialCnt SHALL be tied to 8'h0.

Verification
REQ-034 Reset, then push 32'h3F800000, 32'h3F3504F3, 32'h3F000000 on consecutive cycles with DataOutReady=0 -> Count=3, DataOut=32'h3F800000; then assert DataOutReady for 3 cycles -> DataOut shows the words in order, and Empty=1 at the end.
REQ-035 Push 17 words (32'h00000001..32'h00000011) with DataOutReady=0 at DEPTH=16 -> Full=1 after the 16th, Overflow=1 after the 17th, 16 words read back ending with 32'h00000010, and SampleCnt=16.
REQ-036 Full FIFO, DataInValid=1 with DataOutReady=1 every cycle for 40 cycles -> Count stays 16, Overflow stays 0, and the read/write pointers wrap at least twice with order preserved.
REQ-037 Push 5 words, assert rst for 1 cycle with DataInValid=1 -> Count=0, Empty=1, DataOut=32'h0, SampleCnt=0; the next push 32'hDEADBEEF is output first.
REQ-038 With INVSQRT_SPECIAL_CHECK_EN defined, push 32'h7FC00000, 32'h7F800000, 32'h3F800000 -> Count=1, SpecialCnt=2, SampleCnt=1; without the macro -> Count=3, SpecialCnt=0.
